// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Requester identifiers, also used as the last_grant encoding
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Clears the byte offset to form a word address
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Request captured at grant time and replayed to memory
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              id;
  } mem_txn_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the side not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req_inst,
  input  logic i_req_data,
  input  logic i_last_grant,
  output logic o_grant_c
);

  // Tie goes to the opposite of the last grant; a lone request always wins
  always_comb begin
    o_grant_c = REQ_I;
    if (i_req_inst && i_req_data) begin
      o_grant_c = ~i_last_grant;
    end else if (i_req_data) begin
      o_grant_c = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared memory.
// Each grant takes IDLE -> ACCESS -> RESP, one cycle per state.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  mem_txn_t          r_txn;
  mem_txn_t          w_txn_sel;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  w_stall_nxt;
  logic [CNT_W:0]    w_stall_sum;
  logic [1:0]        w_stall_inc;
  logic              w_grant;
  logic              w_latch;
  logic              w_capture;
  logic              w_busy;
  logic              w_wait_i;
  logic              w_wait_d;

  rr_arb2 u_rr_arb2 (
    .i_req_inst   (i_req),
    .i_req_data   (d_req),
    .i_last_grant (r_last_grant),
    .o_grant_c    (w_grant)
  );

  // Payload of whichever requester the picker selected
  always_comb begin
    w_txn_sel = '0;
    if (w_grant == REQ_D) begin
      w_txn_sel.addr  = d_addr;
      w_txn_sel.wdata = d_wdata;
      w_txn_sel.we    = d_we;
      w_txn_sel.id    = REQ_D;
    end else begin
      w_txn_sel.addr  = i_addr;
      w_txn_sel.id    = REQ_I;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and memory/ready outputs; reset masks store and ready pulses
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
        mem_addr    = r_txn.addr & WORD_MASK;
        mem_wdata   = r_txn.wdata;
        mem_read    = ~r_txn.we;
        mem_write   = r_txn.we & ~reset;
        w_capture   = ~r_txn.we;
      end
      RESP: begin
        w_state_nxt = IDLE;
        i_ready     = (r_txn.id == REQ_I) & ~reset;
        d_ready     = (r_txn.id == REQ_D) & ~reset;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant latch, round-robin history and load-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txn        <= '0;
      r_last_grant <= REQ_D;
      r_rdata      <= '0;
    end else begin
      if (w_latch) begin
        r_txn        <= w_txn_sel;
        r_last_grant <= w_grant;
      end
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // A requester waits whenever it asks but is not the one being served
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_wait_i    = i_req & ~(w_busy & (r_txn.id == REQ_I));
    w_wait_d    = d_req & ~(w_busy & (r_txn.id == REQ_D));
    w_stall_inc = {1'b0, w_wait_i} + {1'b0, w_wait_d};
    w_stall_sum = {1'b0, r_stall_cnt} + (CNT_W+1)'(w_stall_inc);
    w_stall_nxt = w_stall_sum[CNT_W] ? CNT_MAX : w_stall_sum[CNT_W-1:0];
  end

  // Saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
    end
  end

  assign i_rdata   = r_rdata;
  assign d_rdata   = r_rdata;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// two-requester traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .stall_cnt (stall_cnt)
  );

  // Shared memory seen by the DUT: combinational read, write on clock edge
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  int unsigned n_mem_writes;

  // Reference model: counts cycles, remembers the one transaction in flight
  logic [31:0] gmem [0:255];
  int unsigned cyc;
  bit          has_txn;
  int unsigned t_cyc;
  bit          t_side;
  bit          t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  bit          last_d;
  logic [31:0] m_rdata;
  int unsigned m_stall;
  bit          exp_i_rdy;
  bit          exp_d_rdy;

  // Requester agents
  bit i_pend;
  bit d_pend;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs the DUT saw
  task automatic model_update();
    int unsigned x;
    bit          busy;
    int unsigned inc;
    bit          win;
    x = cyc;
    cyc++;
    if (reset) begin
      has_txn = 1'b0;
      last_d  = 1'b1;
      m_rdata = '0;
      m_stall = 0;
      return;
    end
    busy = has_txn && (x == t_cyc || x == t_cyc + 1);
    inc  = 0;
    if (i_req && !(busy && t_side == 1'b0)) inc++;
    if (d_req && !(busy && t_side == 1'b1)) inc++;
    m_stall = (m_stall + inc > 65535) ? 65535 : m_stall + inc;
    if (has_txn && x == t_cyc) begin
      if (t_we) gmem[t_addr[9:2]] = t_wdata;
      else      m_rdata = gmem[t_addr[9:2]];
    end
    if (!busy && (i_req || d_req)) begin
      if (i_req && d_req) win = !last_d;
      else                win = d_req;
      has_txn = 1'b1;
      t_cyc   = cyc;
      t_side  = win;
      last_d  = win;
      if (win) begin
        t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
      end else begin
        t_addr = i_addr; t_we = 1'b0; t_wdata = '0;
      end
    end
  endtask

  // Compare every DUT output with the model for the current cycle
  task automatic model_check();
    bit acc;
    bit rsp;
    if (reset) begin
      exp_i_rdy = 1'b0;
      exp_d_rdy = 1'b0;
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_i_ready", i_ready, 0);
      check_eq("rst_d_ready", d_ready, 0);
      return;
    end
    acc = has_txn && cyc == t_cyc;
    rsp = has_txn && cyc == t_cyc + 1;
    exp_i_rdy = rsp && !t_side;
    exp_d_rdy = rsp && t_side;
    check_eq("mem_read",  mem_read,  acc && !t_we);
    check_eq("mem_write", mem_write, acc && t_we);
    check_eq("mem_addr",  mem_addr,  acc ? {t_addr[31:2], 2'b00} : 32'h0);
    check_eq("mem_wdata", mem_wdata, acc ? t_wdata : 32'h0);
    check_eq("i_ready",   i_ready,   exp_i_rdy);
    check_eq("d_ready",   d_ready,   exp_d_rdy);
    check_eq("i_rdata",   i_rdata,   m_rdata);
    check_eq("d_rdata",   d_rdata,   m_rdata);
    check_eq("stall_cnt", stall_cnt, m_stall);
  endtask

  // One clock: memory write and model step at the edge, checks mid-cycle
  task automatic tick();
    @(posedge clk);
    if (mem_write === 1'b1) begin
      mem[mem_addr[9:2]] = mem_wdata;
      n_mem_writes++;
    end
    model_update();
    @(negedge clk);
    model_check();
  endtask

  // Random protocol-following requesters; occasional early drop if allowed
  task automatic agents(input int p_new, input bit allow_drop);
    if (i_pend && exp_i_rdy) i_pend = 1'b0;
    else if (i_pend && allow_drop && $urandom_range(0, 63) == 0) i_pend = 1'b0;
    if (!i_pend && $urandom_range(0, 99) < p_new) begin
      i_pend = 1'b1;
      i_addr = $urandom_range(0, 1023);
    end
    i_req = i_pend;
    if (d_pend && exp_d_rdy) d_pend = 1'b0;
    else if (d_pend && allow_drop && $urandom_range(0, 63) == 0) d_pend = 1'b0;
    if (!d_pend && $urandom_range(0, 99) < p_new) begin
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom_range(0, 1023);
      d_wdata = $urandom();
    end
    d_req = d_pend;
  endtask

  // One data-side transaction from IDLE; returns what the DUT showed
  task automatic do_dtxn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] acc_addr, output logic rdy, output logic [31:0] rdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    tick();
    acc_addr = mem_addr;
    tick();
    rdy   = d_ready;
    rdata = d_rdata;
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic        r;
    logic [31:0] q;
    int unsigned w0;
    int          ev_cyc  [0:7];
    int          ev_side [0:7];
    int          n_ev;
    int          extra;

    n_checks = 0; n_fail = 0; n_mem_writes = 0;
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = '0;
      gmem[i] = '0;
    end
    mem[0]  = 32'h20040005;
    gmem[0] = 32'h20040005;
    cyc = 0; has_txn = 1'b0; t_cyc = 0; t_side = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; last_d = 1'b1; m_rdata = '0; m_stall = 0;
    exp_i_rdy = 1'b0; exp_d_rdy = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev_cyc[i] = 0; ev_side[i] = 0;
    end

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_i_ready",   i_ready,   0);
    check_eq("post_rst_d_ready",   d_ready,   0);
    check_eq("post_rst_mem_read",  mem_read,  0);
    check_eq("post_rst_mem_write", mem_write, 0);
    check_eq("post_rst_mem_addr",  mem_addr,  0);
    check_eq("post_rst_rdata",     i_rdata,   0);
    check_eq("post_rst_stall",     stall_cnt, 0);

    // Single instruction fetch from address 0
    i_req = 1'b1; i_addr = 32'h0;
    tick();
    tick();
    check_eq("fetch_i_ready", i_ready, 1);
    check_eq("fetch_i_rdata", i_rdata, 32'h20040005);
    check_eq("fetch_d_ready", d_ready, 0);
    i_req = 1'b0;
    tick();

    // Store then load, then misaligned load of the same word
    w0 = n_mem_writes;
    do_dtxn(1'b1, 32'h80, 32'hDEADBEEF, a, r, q);
    check_eq("store_ready", r, 1);
    check_eq("store_mw_cycles", n_mem_writes - w0, 1);
    do_dtxn(1'b0, 32'h80, 32'h0, a, r, q);
    check_eq("load_ready", r, 1);
    check_eq("load_rdata", q, 32'hDEADBEEF);
    do_dtxn(1'b0, 32'h83, 32'h0, a, r, q);
    check_eq("misalign_addr", a, 32'h80);
    check_eq("misalign_rdata", q, 32'hDEADBEEF);

    // Reset during the ACCESS cycle of a store aborts it
    w0 = n_mem_writes;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'h12345678;
    tick();
    reset = 1'b1;
    #1;
    check_eq("abort_mw_in_rst", mem_write, 0);
    d_req = 1'b0;
    tick();
    check_eq("abort_no_ready", d_ready, 0);
    reset = 1'b0;
    tick();
    check_eq("abort_no_ready2", d_ready, 0);
    check_eq("abort_no_write", n_mem_writes - w0, 0);
    do_dtxn(1'b0, 32'h84, 32'h0, a, r, q);
    check_eq("abort_load_ready", r, 1);
    check_eq("abort_load_rdata", q, 32'h0);

    // Both requesters held from reset: alternating grants every 3 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    n_ev = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (i_ready === 1'b1 && n_ev < 8) begin ev_cyc[n_ev] = k; ev_side[n_ev] = 0; n_ev++; end
      if (d_ready === 1'b1 && n_ev < 8) begin ev_cyc[n_ev] = k; ev_side[n_ev] = 1; n_ev++; end
    end
    check_eq("rr_n_events", n_ev, 4);
    for (int n = 0; n < 4; n++) begin
      check_eq($sformatf("rr_cycle_%0d", n), ev_cyc[n], 2 + 3 * n);
      check_eq($sformatf("rr_side_%0d", n), ev_side[n], n % 2);
    end
    check_eq("rr_stall", stall_cnt, 15);

    // Random traffic with occasional early request drops
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      agents(40, 1'b1);
    end

    // Continuous contention until the stall counter saturates
    extra = 0;
    for (int k = 0; k < 60000 && extra < 30; k++) begin
      tick();
      agents(100, 1'b0);
      if (m_stall == 65535) extra++;
    end
    check_eq("sat_final", stall_cnt, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
